// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Absolute branch targets, indexed by the instruction's PCTarg field.
  localparam logic [PC_W-1:0] ABS_TARG [4] = '{10'd0, 10'd16, 10'd64, 10'd200};

  // Relative branch offsets, 8-bit two's complement.
  localparam logic signed [7:0] REL_OFFS [4] = '{-8'sd3, 8'sd5, -8'sd16, 8'sd2};

  // Encoding of the done instruction; the decoder raises Ack when it sees it.
  localparam logic [8:0] DONE_INST = 9'h1FF;

  // Sign-extend an 8-bit offset to the PC width.
  function automatic logic [PC_W-1:0] sext_offs(input logic signed [7:0] offs);
    return {{(PC_W-8){offs[7]}}, offs};
  endfunction

endpackage

// File: rtl/pc_sequencer_target_lut.sv
// Combinational lookup of the absolute target and sign-extended relative
// offset selected by PCTarg.
module pc_target_lut
  import pc_sequencer_pkg::*;
(
  input  logic [1:0]      pc_targ,
  output logic [PC_W-1:0] abs_targ,
  output logic [PC_W-1:0] rel_offs
);

  // Both table outputs are produced every cycle; the sequencer picks one.
  always_comb begin
    abs_targ = ABS_TARG[pc_targ];
    rel_offs = sext_offs(REL_OFFS[pc_targ]);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the instruction ROM address, applies
// absolute and flag-qualified relative branches, and halts on the done
// instruction until restarted.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            BranchAbs,
  input  logic            BranchRel,
  input  logic            Taken,
  input  logic [1:0]      PCTarg,
  input  logic            Ack,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done
);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] abs_targ;
  logic [PC_W-1:0] rel_offs;

  pc_target_lut u_lut (
    .pc_targ  (PCTarg),
    .abs_targ (abs_targ),
    .rel_offs (rel_offs)
  );

  // Next state and next PC; inside RUN the branches are strictly prioritised
  // with restart first and the done instruction ahead of any branch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) state_d = RUN;
      end
      RUN: begin
        if (Start) begin
          pc_d = '0;
        end else if (Ack) begin
          state_d = HALT;
        end else if (BranchAbs) begin
          pc_d = abs_targ;
        end else if (BranchRel && Taken) begin
          pc_d = pc_q + rel_offs;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == HALT);
  end

  // State, PC and status flags; reset returns everything to idle at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule
